screen_rmw_scanner: RTL
=======================

Name: screen_rmw_scanner

Overview:
- Responder side of the screen draw interface; drawing clients (triangle, rectangle, sprite fillers) are the initiators.
- On start, walks the client's bounding box in raster order. For each pixel it reads the framebuffer, presents (x, y, old colour) to the client, then writes the client's combinational new colour back.
- Sits between the drawing clients and the dual-port framebuffer RAM. Pulses done when the box is finished.

Parameters:
- WIDTH, 8, bit width of coordinates and ranges.
- COLOUR_WIDTH, 3, pixel colour width.
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped.
- ADDR_WIDTH, 15, framebuffer address width; address = y*SCREEN_W + x.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- screen_start  in  1  level request from client; sampled only in S_IDLE.
- screen_x_min  in  WIDTH  box left edge.
- screen_y_min  in  WIDTH  box top edge.
- screen_x_range  in  WIDTH  box width minus 1 (inclusive).
- screen_y_range  in  WIDTH  box height minus 1 (inclusive).
- new_screen_colour  in  COLOUR_WIDTH  client's colour for the current pixel (combinational on the client side).
- screen_x  out  WIDTH  current pixel x.
- screen_y  out  WIDTH  current pixel y.
- old_screen_colour  out  COLOUR_WIDTH  framebuffer contents at the current pixel.
- screen_done  out  1  one-cycle pulse, scan complete.
- busy  out  1  high in every state except S_IDLE.
- fb_rd_addr  out  ADDR_WIDTH  framebuffer read address; synchronous read, 1-cycle latency.
- fb_rd_data  in  COLOUR_WIDTH  framebuffer read data.
- fb_wr_en  out  1  framebuffer write strobe.
- fb_wr_addr  out  ADDR_WIDTH  framebuffer write address.
- fb_wr_data  out  COLOUR_WIDTH  framebuffer write data.

Behaviour:
- Reset: state S_IDLE; screen_x, screen_y, old_screen_colour, fb_rd_addr, fb_wr_addr, fb_wr_data all 0; screen_done, busy, fb_wr_en all 0. Reset wins over every other event.
- Reset mid-scan: abort with no done pulse and no further writes; fb_wr_en is 0 in the cycle after reset is sampled.
- States: S_IDLE, S_FETCH, S_CAPTURE, S_WRITE, S_DONE.
- S_IDLE
  - If screen_start=1, latch min and range into internal registers, set x=x_min, y=y_min, go to S_FETCH.
  - Input changes after the latch have no effect until the next scan.
- S_FETCH
  - Pixel clipped: no read; advance; occupies 1 cycle.
  - Otherwise: drive fb_rd_addr, go to S_CAPTURE.
- S_CAPTURE: register fb_rd_data into old_screen_colour; go to S_WRITE.
- S_WRITE
  - fb_wr_en=1, fb_wr_addr = current address, fb_wr_data = new_screen_colour.
  - Advance to the next pixel.
- Advance rule
  - Next pixel: if x == x_min+x_range, wrap to x=x_min, y+1; else x+1.
  - After the last pixel (x == x_min+x_range and y == y_min+y_range), go to S_DONE; otherwise go to S_FETCH.
- Counters are WIDTH+1 bits, so x_min+x_range never wraps. Coordinates beyond 2^WIDTH-1 are always clipped.
- screen_x and screen_y hold the low WIDTH bits and stay stable from S_FETCH through S_WRITE of a pixel.
- S_DONE: screen_done=1 for exactly one cycle, then S_IDLE. If screen_start is still high, a new scan latches on the following S_IDLE cycle.
- Timing: unclipped pixel 3 cycles; clipped pixel 1 cycle; plus 1 cycle for S_DONE.
- Fully clipped box: no reads, no writes, done is still pulsed.
- fb_wr_en is 0 outside S_WRITE. fb_rd_addr holds its value outside S_FETCH.

Optional Feature:
- Macro: SCREEN_SKIP_UNCHANGED_EN.
- Defined: in S_WRITE, fb_wr_en=0 when new_screen_colour == old_screen_colour. Cycle timing is unchanged.
- Undefined: every unclipped pixel is written unconditionally.

Decomposition:
- Shared package screen_pkg holds:
  - state encodings S_IDLE..S_DONE;
  - SCREEN_W and SCREEN_H defaults;
  - the ADDR_WIDTH constant;
  - the colour typedef.
- Sub-module screen_addr_calc: combinational (x, y) -> y*SCREEN_W + x, with clip flag output (x>=SCREEN_W or y>=SCREEN_H). Instantiated once and shared by the read and write address paths.

Test Plan:
- Single pixel: start with min (5,7), ranges (0,0); fb[1125]=3; client returns 6.
  - fb_rd_addr=1125; old_screen_colour=3 in S_WRITE.
  - One write: addr 1125, data 6.
  - screen_done high 4 cycles after the start sample.
- 3x2 box: min (0,0), ranges (2,1).
  - Writes in order to addresses 0, 1, 2, 160, 161, 162.
  - screen_done at cycle 19.
  - busy high cycles 1-19.
- Clipping: min (158,118), ranges (3,3).
  - Only 158/159 x 118/119 are read and written (addresses 19038, 19039, 19198, 19199).
  - 12 clipped pixels produce no fb activity.
  - Done at cycle 25.
- Reset mid-scan: 3x2 box, reset in S_WRITE of pixel 2.
  - No further writes; screen_done never pulses; busy=0 next cycle.
  - A later start completes normally.
- screen_start held high through two scans: second scan begins in the S_IDLE cycle right after the done pulse. Box inputs changed during scan 1 affect only scan 2.
- SCREEN_SKIP_UNCHANGED_EN: 2x2 box, client echoes old colour.
  - Macro defined: zero fb_wr_en pulses.
  - Macro undefined: 4 pulses.
  - Done cycle identical in both builds.

Source files
------------

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared states, screen geometry defaults and colour type for the screen scanner
package screen_pkg;
   localparam int SCREEN_W_DEF  = 160;
   localparam int SCREEN_H_DEF  = 120;
   localparam int FB_ADDR_WIDTH = 15;
   localparam int COLOUR_W      = 3;

   typedef logic [COLOUR_W-1:0] colour_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_WRITE,
      S_DONE
   } state_t;
endpackage

// File: rtl/screen_addr_calc.sv
// rtl/screen_addr_calc.sv - (x, y) to linear framebuffer address, with off-screen clip flag
module screen_addr_calc
   import screen_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SCREEN_W   = SCREEN_W_DEF,
   parameter int SCREEN_H   = SCREEN_H_DEF,
   parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
   input  logic [WIDTH:0]        x,
   input  logic [WIDTH:0]        y,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  clip
);

   // Address is only meaningful when clip is low, so truncation of off-screen products is harmless.
   assign addr = ADDR_WIDTH'(y) * ADDR_WIDTH'(SCREEN_W) + ADDR_WIDTH'(x);
   assign clip = (32'(x) >= SCREEN_W) || (32'(y) >= SCREEN_H);

endmodule

// File: rtl/screen_rmw_scanner.sv
// rtl/screen_rmw_scanner.sv - raster read-modify-write scanner over a client bounding box
// Optional macro SCREEN_SKIP_UNCHANGED_EN suppresses writes whose colour is unchanged.
module screen_rmw_scanner
   import screen_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int COLOUR_WIDTH = COLOUR_W,
   parameter int SCREEN_W     = SCREEN_W_DEF,
   parameter int SCREEN_H     = SCREEN_H_DEF,
   parameter int ADDR_WIDTH   = FB_ADDR_WIDTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    screen_start,
   input  logic [WIDTH-1:0]        screen_x_min,
   input  logic [WIDTH-1:0]        screen_y_min,
   input  logic [WIDTH-1:0]        screen_x_range,
   input  logic [WIDTH-1:0]        screen_y_range,
   input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
   output logic [WIDTH-1:0]        screen_x,
   output logic [WIDTH-1:0]        screen_y,
   output logic [COLOUR_WIDTH-1:0] old_screen_colour,
   output logic                    screen_done,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   fb_rd_addr,
   input  logic [COLOUR_WIDTH-1:0] fb_rd_data,
   output logic                    fb_wr_en,
   output logic [ADDR_WIDTH-1:0]   fb_wr_addr,
   output logic [COLOUR_WIDTH-1:0] fb_wr_data
);

   state_t                  state_q, state_d;
   logic [WIDTH:0]          x_q, x_d, y_q, y_d;
   logic [WIDTH:0]          x_end_q, x_end_d, y_end_q, y_end_d;
   logic [WIDTH-1:0]        x_min_q, x_min_d;
   logic [COLOUR_WIDTH-1:0] old_q, old_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic                    done_q, done_d, busy_q, busy_d, wr_phase_q, wr_phase_d;

   logic [ADDR_WIDTH-1:0]   pix_addr;
   logic                    pix_clip;
   logic                    last_pix;
   logic [WIDTH:0]          adv_x, adv_y;

   screen_addr_calc #(
      .WIDTH      (WIDTH),
      .SCREEN_W   (SCREEN_W),
      .SCREEN_H   (SCREEN_H),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_calc (
      .x    (x_q),
      .y    (y_q),
      .addr (pix_addr),
      .clip (pix_clip)
   );

   // The read address must be valid during S_FETCH itself, so it bypasses the hold register there.
   assign fb_rd_addr = (state_q == S_FETCH && !pix_clip) ? pix_addr : rd_addr_q;

   always_comb begin
      last_pix = (x_q == x_end_q) && (y_q == y_end_q);
      if (x_q == x_end_q) begin
         adv_x = {1'b0, x_min_q};
         adv_y = y_q + (WIDTH+1)'(1);
      end else begin
         adv_x = x_q + (WIDTH+1)'(1);
         adv_y = y_q;
      end

      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      x_min_d    = x_min_q;
      old_d      = old_q;
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = fb_rd_addr;
      done_d     = 1'b0;
      wr_phase_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (screen_start) begin
               x_min_d = screen_x_min;
               x_d     = {1'b0, screen_x_min};
               y_d     = {1'b0, screen_y_min};
               x_end_d = {1'b0, screen_x_min} + {1'b0, screen_x_range};
               y_end_d = {1'b0, screen_y_min} + {1'b0, screen_y_range};
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (pix_clip) begin
               x_d     = adv_x;
               y_d     = adv_y;
               done_d  = last_pix;
               state_d = last_pix ? S_DONE : S_FETCH;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            old_d      = fb_rd_data;
            wr_addr_d  = pix_addr;
            wr_phase_d = 1'b1;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            x_d     = adv_x;
            y_d     = adv_y;
            done_d  = last_pix;
            state_d = last_pix ? S_DONE : S_FETCH;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         x_end_q    <= '0;
         y_end_q    <= '0;
         x_min_q    <= '0;
         old_q      <= '0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         wr_phase_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         x_end_q    <= x_end_d;
         y_end_q    <= y_end_d;
         x_min_q    <= x_min_d;
         old_q      <= old_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         wr_phase_q <= wr_phase_d;
      end
   end

   assign screen_x          = x_q[WIDTH-1:0];
   assign screen_y          = y_q[WIDTH-1:0];
   assign old_screen_colour = old_q;
   assign screen_done       = done_q;
   assign busy              = busy_q;
   assign fb_wr_addr        = wr_addr_q;
   // Client colour is combinational on the current pixel, so write data follows it live in S_WRITE.
   assign fb_wr_data        = wr_phase_q ? new_screen_colour : '0;

`ifdef SCREEN_SKIP_UNCHANGED_EN
   assign fb_wr_en = wr_phase_q && (new_screen_colour != old_q);
`else
   assign fb_wr_en = wr_phase_q;
`endif

endmodule
